// File: rtl/display_arbiter.sv
// display_arbiter: owns the 4-digit display path and shares display_driver between two
// requesters (req0 = CPU register path, req1 = status/debug source). Ownership changes
// are sequenced as brightness fade-out, content swap, fade-in. Each owner keeps the
// display for at least HOLD_CYCLES after its last accepted write.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req{0,1}_valid/_data/_mode/_ready
//                          update handshake; a transfer happens on valid & ready
//   cfg_brightness         target brightness while content is shown
//   display_data/_mode     content to the driver (registered)
//   brightness             current brightness to the driver (registered)
//   pwm_period             constant PWM_PERIOD
//   owner                  00 none, 01 req0, 10 req1 (registered)
//   busy                   high while fading in or out (registered)
module display_arbiter #(
    parameter int unsigned HOLD_CYCLES      = 1000,
    parameter int unsigned FADE_STEP_CYCLES = 256,
    parameter logic [15:0] PWM_PERIOD       = 16'h0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    input  logic [1:0]  req0_mode,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    input  logic [1:0]  req1_mode,
    output logic        req1_ready,
    input  logic [1:0]  cfg_brightness,
    output logic [31:0] display_data,
    output logic [1:0]  display_mode,
    output logic [1:0]  brightness,
    output logic [15:0] pwm_period,
    output logic [1:0]  owner,
    output logic        busy
);

    localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned SW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
    localparam logic [HW-1:0] HoldLoad = HW'(HOLD_CYCLES);
    localparam logic [SW-1:0] StepLast = SW'(FADE_STEP_CYCLES - 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StFadeIn  = 2'd1;
    localparam logic [1:0] StShow    = 2'd2;
    localparam logic [1:0] StFadeOut = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   data_q, data_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    bright_q, bright_d;
    logic [1:0]    owner_q, owner_d;
    logic          busy_q, busy_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [SW-1:0] step_q, step_d;
    // Tie-break favourite: 0 = req0 wins a simultaneous request, 1 = req1 wins.
    logic          prio_q, prio_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic [1:0]    pend_mode_q, pend_mode_d;
    logic [1:0]    pend_owner_q, pend_owner_d;

    // Arbitration / ownership helpers
    logic          grant0, grant1;
    logic          hold_zero;
    logic          own_is1;
    logic          own_valid, non_valid;
    logic          own_ready, non_ready;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        mode_d       = mode_q;
        bright_d     = bright_q;
        owner_d      = owner_q;
        hold_d       = hold_q;
        step_d       = step_q;
        prio_d       = prio_q;
        pend_data_d  = pend_data_q;
        pend_mode_d  = pend_mode_q;
        pend_owner_d = pend_owner_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        grant0       = 1'b0;
        grant1       = 1'b0;
        hold_zero    = (hold_q == '0);
        own_is1      = owner_q[1];
        own_valid    = own_is1 ? req1_valid : req0_valid;
        non_valid    = own_is1 ? req0_valid : req1_valid;
        own_ready    = 1'b0;
        non_ready    = 1'b0;

        case (state_q)
            StIdle: begin
                grant1     = req1_valid && (!req0_valid || prio_q);
                grant0     = req0_valid && !grant1;
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    data_d  = grant1 ? req1_data : req0_data;
                    mode_d  = grant1 ? req1_mode : req0_mode;
                    owner_d = grant1 ? 2'b10 : 2'b01;
                    prio_d  = grant0;
                    step_d  = '0;
                    state_d = StFadeIn;
                end
            end

            StFadeIn: begin
                // Live comparison so a lowered target (even 0) ends the fade at once.
                if (bright_q >= cfg_brightness) begin
                    hold_d  = HoldLoad;
                    step_d  = '0;
                    state_d = StShow;
                end else if (step_q == StepLast) begin
                    step_d = '0;
                    if (bright_q != 2'd3) begin
                        bright_d = bright_q + 2'd1;
                    end
                end else begin
                    step_d = step_q + SW'(1);
                end
            end

            StShow: begin
                bright_d = cfg_brightness;
                if (!hold_zero) begin
                    hold_d = hold_q - HW'(1);
                end
                non_ready = hold_zero;
                // Once the hold has expired a waiting non-owner takes precedence.
                own_ready = !(hold_zero && non_valid);
                if (own_is1) begin
                    req1_ready = own_ready;
                    req0_ready = non_ready;
                end else begin
                    req0_ready = own_ready;
                    req1_ready = non_ready;
                end
                if (non_valid && non_ready) begin
                    pend_data_d  = own_is1 ? req0_data : req1_data;
                    pend_mode_d  = own_is1 ? req0_mode : req1_mode;
                    pend_owner_d = own_is1 ? 2'b01 : 2'b10;
                    step_d       = '0;
                    state_d      = StFadeOut;
                end else if (own_valid && own_ready) begin
                    data_d = own_is1 ? req1_data : req0_data;
                    mode_d = own_is1 ? req1_mode : req0_mode;
                    hold_d = HoldLoad;
                end
            end

            StFadeOut: begin
                if (bright_q == 2'd0) begin
                    // Display is dark: swap in the pending content.
                    data_d  = pend_data_q;
                    mode_d  = pend_mode_q;
                    owner_d = pend_owner_q;
                    prio_d  = pend_owner_q[0];
                    step_d  = '0;
                    state_d = StFadeIn;
                end else if (step_q == StepLast) begin
                    step_d   = '0;
                    bright_d = bright_q - 2'd1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StFadeIn) || (state_d == StFadeOut);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            data_q       <= '0;
            mode_q       <= 2'b11;
            bright_q     <= 2'd0;
            owner_q      <= 2'b00;
            busy_q       <= 1'b0;
            hold_q       <= '0;
            step_q       <= '0;
            prio_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_mode_q  <= 2'b00;
            pend_owner_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            mode_q       <= mode_d;
            bright_q     <= bright_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            hold_q       <= hold_d;
            step_q       <= step_d;
            prio_q       <= prio_d;
            pend_data_q  <= pend_data_d;
            pend_mode_q  <= pend_mode_d;
            pend_owner_q <= pend_owner_d;
        end
    end

    assign display_data = data_q;
    assign display_mode = mode_q;
    assign brightness   = bright_q;
    assign owner        = owner_q;
    assign busy         = busy_q;
    assign pwm_period   = PWM_PERIOD;

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed bench for display_arbiter with short hold/fade timing.
module tb_display_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic [1:0]  req0_mode;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic [1:0]  req1_mode;
    logic        req1_ready;
    logic [1:0]  cfg_brightness;
    logic [31:0] display_data;
    logic [1:0]  display_mode;
    logic [1:0]  brightness;
    logic [15:0] pwm_period;
    logic [1:0]  owner;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    display_arbiter #(
        .HOLD_CYCLES      (100),
        .FADE_STEP_CYCLES (4),
        .PWM_PERIOD       (16'h0020)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_data      (req0_data),
        .req0_mode      (req0_mode),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_data      (req1_data),
        .req1_mode      (req1_mode),
        .req1_ready     (req1_ready),
        .cfg_brightness (cfg_brightness),
        .display_data   (display_data),
        .display_mode   (display_mode),
        .brightness     (brightness),
        .pwm_period     (pwm_period),
        .owner          (owner),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic blocked;
        logic found;
        int   exp_b;

        rst            = 1'b1;
        req0_valid     = 1'b0;
        req0_data      = '0;
        req0_mode      = 2'b00;
        req1_valid     = 1'b0;
        req1_data      = '0;
        req1_mode      = 2'b00;
        cfg_brightness = 2'b11;
        tick();
        tick();

        // ---- reset values
        check("rst_data", display_data, 32'h0);
        check("rst_mode", display_mode, 2'b11);
        check("rst_bright", brightness, 2'd0);
        check("rst_owner", owner, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("pwm_period", pwm_period, 16'h0020);

        // ---- scenario 1: req0 first grant, fade in, owner rewrite, takeover by req1
        rst        = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 32'h6F3A4C0F;
        req0_mode  = 2'b11;
        settle();
        check("s1_r0_ready", req0_ready, 1'b1);
        check("s1_r1_ready", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        check("s1_owner", owner, 2'b01);
        check("s1_data", display_data, 32'h6F3A4C0F);
        check("s1_mode", display_mode, 2'b11);
        check("s1_busy", busy, 1'b1);
        check("s1_bright0", brightness, 2'd0);
        for (int i = 1; i <= 13; i++) begin
            tick();
            exp_b = (i >= 12) ? 3 : i / 4;
            check("s1_fade_in_bright", brightness, exp_b);
            check("s1_fade_in_busy", busy, (i < 13) ? 1 : 0);
        end

        // In SHOW, hold=100. req1 waits during req0's hold.
        req1_valid = 1'b1;
        req1_data  = 32'hDEADBEEF;
        req1_mode  = 2'b10;
        settle();
        check("s1_r1_blocked", req1_ready, 1'b0);
        repeat (49) tick();
        req0_valid = 1'b1;
        req0_data  = 32'h12345678;
        req0_mode  = 2'b01;
        settle();
        check("s1_owner_ready", req0_ready, 1'b1);
        check("s1_r1_still_blocked", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        check("s1_rewrite_data", display_data, 32'h12345678);
        check("s1_rewrite_mode", display_mode, 2'b01);
        check("s1_rewrite_bright", brightness, 2'd3);
        check("s1_rewrite_busy", busy, 1'b0);

        blocked = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (req1_ready) blocked = 1'b1;
            tick();
        end
        check("s1_hold_restart", blocked, 1'b0);
        #1;
        check("s1_r1_ready_after_hold", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        check("s1_fo_busy", busy, 1'b1);
        check("s1_fo_owner", owner, 2'b01);
        for (int j = 1; j <= 13; j++) begin
            tick();
            exp_b = (j < 4) ? 3 : (j < 8) ? 2 : (j < 12) ? 1 : 0;
            check("s1_fade_out_bright", brightness, exp_b);
            check("s1_fade_out_data", display_data, (j < 13) ? 32'h12345678 : 32'hDEADBEEF);
        end
        check("s1_swap_owner", owner, 2'b10);
        check("s1_swap_mode", display_mode, 2'b10);
        check("s1_swap_busy", busy, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp_b = (k >= 12) ? 3 : k / 4;
            check("s1_refade_bright", brightness, exp_b);
        end
        check("s1_refade_busy", busy, 1'b0);

        // ---- scenario 2: both valid in IDLE, then conflict after hold
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 32'hAAAA0000;
        req0_mode  = 2'b00;
        req1_valid = 1'b1;
        req1_data  = 32'hBBBB1111;
        req1_mode  = 2'b01;
        settle();
        check("s2_idle_r0_ready", req0_ready, 1'b1);
        check("s2_idle_r1_ready", req1_ready, 1'b0);
        tick();
        check("s2_owner", owner, 2'b01);
        check("s2_data", display_data, 32'hAAAA0000);
        check("s2_fi_r0_ready", req0_ready, 1'b0);
        check("s2_fi_r1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (120) tick();
        req0_valid = 1'b1;
        req0_data  = 32'hCCCC2222;
        req1_valid = 1'b1;
        settle();
        check("s2_conflict_r0_ready", req0_ready, 1'b0);
        check("s2_conflict_r1_ready", req1_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("s2_fo_busy", busy, 1'b1);
        check("s2_fo_data", display_data, 32'hAAAA0000);
        check("s2_fo_owner", owner, 2'b01);

        // ---- scenario 3: lowered target during fade-in, then 0 in SHOW
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        cfg_brightness = 2'b11;
        req0_valid     = 1'b1;
        req0_data      = 32'h11112222;
        req0_mode      = 2'b00;
        tick();
        req0_valid = 1'b0;
        repeat (4) tick();
        check("s3_bright1", brightness, 2'd1);
        check("s3_busy_fi", busy, 1'b1);
        cfg_brightness = 2'b01;
        tick();
        check("s3_show_busy", busy, 1'b0);
        check("s3_show_bright", brightness, 2'd1);
        cfg_brightness = 2'b00;
        tick();
        check("s3_cfg0_bright", brightness, 2'd0);
        check("s3_cfg0_busy", busy, 1'b0);
        settle();
        check("s3_show_r0_ready", req0_ready, 1'b1);
        tick();
        tick();
        check("s3_still_show", busy, 1'b0);

        // ---- scenario 4: reset in the middle of a fade-out
        cfg_brightness = 2'b11;
        req1_valid     = 1'b1;
        req1_data      = 32'hCAFEF00D;
        req1_mode      = 2'b00;
        found          = 1'b0;
        for (int w = 0; w < 200 && !found; w++) begin
            #1;
            if (req1_ready) found = 1'b1;
            else tick();
        end
        check("s4_wait_r1_ready", found, 1'b1);
        tick();
        req1_valid = 1'b0;
        check("s4_fo_busy", busy, 1'b1);
        repeat (4) tick();
        check("s4_fo_bright2", brightness, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        check("s4_async_data", display_data, 32'h0);
        check("s4_async_mode", display_mode, 2'b11);
        check("s4_async_bright", brightness, 2'd0);
        check("s4_async_owner", owner, 2'b00);
        check("s4_async_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("s4_pending_dropped", display_data, 32'h0);
        check("s4_owner_none", owner, 2'b00);
        check("s4_idle_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
